rom_socket_responder: RTL and testbench

// Responder end of a ROM socket (ce_n/oe_n/a in, d out), the device side of the sockets the

---
 rtl/rom_socket_responder.sv | 96 +++++++++
 tb/tb_rom_socket_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_socket_responder.sv
// rom_socket_responder: device side of a ROM socket. An image is streamed in
// over a valid/ready byte port after reset, then socket reads are served from
// internal RAM with one clk_core cycle of latency.
module rom_socket_responder #(
    parameter int                    ADDR_WIDTH = 13,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE = 8'hFF
) (
    input  logic                  clk_core,
    input  logic                  reset_n,
    input  logic                  rom_ce_n,
    input  logic                  rom_oe_n,
    input  logic [ADDR_WIDTH-1:0] rom_a,
    output logic [DATA_WIDTH-1:0] rom_d,
    output logic                  rom_d_oe,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  loaded,
    output logic                  short_load
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_TOP = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic {
        LOAD  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH:0]     count;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   ram_q;
    logic                    hit_q;

    logic xfer;
    logic at_top;
    logic sel;

    // load_ready is only ever high in LOAD, so it alone qualifies a transfer
    assign xfer   = load_valid & load_ready;
    assign at_top = (count == CNT_TOP);
    assign sel    = ~rom_ce_n & ~rom_oe_n;

    // Load sequencer: fills RAM from address 0 and exits on load_last or at the top address
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            state      <= LOAD;
            count      <= '0;
            load_ready <= 1'b0;
            loaded     <= 1'b0;
            short_load <= 1'b0;
        end else if (state == LOAD) begin
            load_ready <= 1'b1;
            if (xfer) begin
                count <= count + 1'b1;
                // reaching the top address wins, so last-on-top is a full image
                if (load_last || at_top) begin
                    state      <= READY;
                    load_ready <= 1'b0;
                    loaded     <= 1'b1;
                    short_load <= ~at_top;
                end
            end
        end
    end

    // Synchronous single-write / single-read RAM; read data held while deselected
    always_ff @(posedge clk_core) begin
        if (xfer) begin
            mem[count[ADDR_WIDTH-1:0]] <= load_data;
        end
        if (sel) begin
            ram_q <= mem[rom_a];
        end
    end

    // Read qualifier: a hit needs a finished image and an address below the final count
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            rom_d_oe <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            rom_d_oe <= sel;
            if (sel) begin
                hit_q <= (state == READY) && ({1'b0, rom_a} < count);
            end
        end
    end

    // Both mux inputs are registers, so rom_d has no path from any input
    assign rom_d = hit_q ? ram_q : FILL_VALUE;

endmodule

// File: tb/tb_rom_socket_responder.sv
// tb_rom_socket_responder: self-checking bench with a behavioural model of the
// image store (array + count + flags), randomized reads/handshakes, a table of
// read vectors and hand-written reset/boundary sequences.
module tb_rom_socket_responder;

    localparam int AW    = 13;
    localparam int DW    = 8;
    localparam int DEPTH = 2 ** AW;
    localparam logic [DW-1:0] FILL = 8'hFF;

    logic          clk_core = 1'b0;
    logic          reset_n  = 1'b0;
    logic          rom_ce_n = 1'b1;
    logic          rom_oe_n = 1'b1;
    logic [AW-1:0] rom_a    = '0;
    logic [DW-1:0] rom_d;
    logic          rom_d_oe;
    logic          load_valid = 1'b0;
    logic [DW-1:0] load_data  = '0;
    logic          load_last  = 1'b0;
    logic          load_ready;
    logic          loaded;
    logic          short_load;

    rom_socket_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FILL_VALUE(FILL)) dut (
        .clk_core   (clk_core),
        .reset_n    (reset_n),
        .rom_ce_n   (rom_ce_n),
        .rom_oe_n   (rom_oe_n),
        .rom_a      (rom_a),
        .rom_d      (rom_d),
        .rom_d_oe   (rom_d_oe),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .loaded     (loaded),
        .short_load (short_load)
    );

    always #5 clk_core = ~clk_core;

    // reference model of the responder
    logic [DW-1:0] m_mem [DEPTH];
    int            m_cnt;
    bit            m_loaded, m_short, m_ready;
    logic [DW-1:0] e_d;
    bit            e_oe;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_loaded = 0; m_short = 0; m_ready = 0;
        e_d = FILL; e_oe = 0;
    endtask

    task automatic chk_all();
        chk("rom_d", 32'(rom_d), 32'(e_d));
        chk("rom_d_oe", 32'(rom_d_oe), 32'(e_oe));
        chk("load_ready", 32'(load_ready), 32'(m_ready));
        chk("loaded", 32'(loaded), 32'(m_loaded));
        chk("short_load", 32'(short_load), 32'(m_short));
    endtask

    // one clock cycle: drive inputs, predict, clock, compare everything
    task automatic cyc(input bit v, input logic [DW-1:0] d, input bit l,
                       input bit ce_n, input bit oe_n, input logic [AW-1:0] a);
        load_valid = v; load_data = d; load_last = l;
        rom_ce_n = ce_n; rom_oe_n = oe_n; rom_a = a;
        if (!ce_n && !oe_n) begin
            e_oe = 1;
            e_d  = (m_loaded && int'(a) < m_cnt) ? m_mem[a] : FILL;
        end else begin
            e_oe = 0;
        end
        if (!m_loaded) begin
            if (v && m_ready) begin
                m_mem[m_cnt] = d;
                m_cnt++;
                if (l || m_cnt == DEPTH) begin
                    m_loaded = 1;
                    m_short  = (m_cnt < DEPTH);
                end
            end
            m_ready = !m_loaded;
        end
        @(posedge clk_core); #1;
        chk_all();
    endtask

    task automatic idle();
        cyc(0, 8'h00, 0, 1, 1, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        cyc(0, 8'h00, 0, 0, 0, a);
    endtask

    // async assert checked mid-cycle, release one cycle later
    task automatic do_reset();
        reset_n = 0;
        #2;
        model_reset();
        chk("rst rom_d", 32'(rom_d), 32'(FILL));
        chk("rst rom_d_oe", 32'(rom_d_oe), 0);
        chk("rst load_ready", 32'(load_ready), 0);
        chk("rst loaded", 32'(loaded), 0);
        chk("rst short_load", 32'(short_load), 0);
        @(posedge clk_core); #1;
        reset_n = 1;
    endtask

    typedef struct {
        bit            ce_n;
        bit            oe_n;
        logic [AW-1:0] a;
        logic [DW-1:0] exp_d;
        bit            exp_oe;
    } rd_vec_t;

    rd_vec_t tbl [6];

    initial begin
        int n;
        logic [AW-1:0] ra;

        // read vectors for the 16-byte short image with data 8'hA0+i
        tbl[0] = '{0, 0, 13'd15,   8'hAF, 1};
        tbl[1] = '{0, 0, 13'd16,   8'hFF, 1};
        tbl[2] = '{0, 0, 13'd0,    8'hA0, 1};
        tbl[3] = '{1, 0, 13'd0,    8'hA0, 0};
        tbl[4] = '{0, 1, 13'd3,    8'hA0, 0};
        tbl[5] = '{0, 0, 13'd8191, 8'hFF, 1};

        #3;
        do_reset();

        // full 8192-byte image, no load_last, random socket reads during load
        n = 0;
        while (!m_loaded && n < 3 * DEPTH) begin
            ra = AW'($urandom);
            cyc(1, 8'(m_cnt) ^ 8'h5A, 0, 1'($urandom), 1'($urandom), ra);
            n++;
        end
        chk("t1 load finished", 32'(m_loaded), 1);
        chk("t1 loaded", 32'(loaded), 1);
        chk("t1 short_load", 32'(short_load), 0);
        chk("t1 load_ready", 32'(load_ready), 0);

        // fixed-address read then deselect
        rd(13'h1234);
        chk("t2 rom_d", 32'(rom_d), 32'h6E);
        chk("t2 rom_d_oe", 32'(rom_d_oe), 1);
        cyc(0, 8'h00, 0, 1, 0, 13'h1234);
        chk("t2 hold rom_d", 32'(rom_d), 32'h6E);
        chk("t2 hold oe", 32'(rom_d_oe), 0);
        for (int i = 0; i < 40; i++) rd(AW'($urandom));

        // short image of 16 bytes
        do_reset();
        idle();
        for (int i = 0; i < 16; i++) cyc(1, 8'hA0 + 8'(i), i == 15, 1, 1, '0);
        chk("t3 loaded", 32'(loaded), 1);
        chk("t3 short_load", 32'(short_load), 1);
        for (int i = 0; i < 6; i++) begin
            cyc(1'($urandom), 8'($urandom), 1'($urandom), tbl[i].ce_n, tbl[i].oe_n, tbl[i].a);
            chk($sformatf("t3 tbl%0d rom_d", i), 32'(rom_d), 32'(tbl[i].exp_d));
            chk($sformatf("t3 tbl%0d oe", i), 32'(rom_d_oe), 32'(tbl[i].exp_oe));
        end

        // read racing the first write, then read back
        do_reset();
        idle();
        cyc(1, 8'h3C, 1, 0, 0, 13'd0);
        chk("t4 race rom_d", 32'(rom_d), 32'(FILL));
        chk("t4 race oe", 32'(rom_d_oe), 1);
        rd(13'd0);
        chk("t4 readback", 32'(rom_d), 32'h3C);
        chk("t4 short", 32'(short_load), 1);

        // reset mid-load, stale RAM must be masked
        do_reset();
        idle();
        for (int i = 0; i < 100; i++) cyc(1, 8'(i) + 8'h11, 0, 1, 1, '0);
        do_reset();
        idle();
        for (int i = 0; i < 4; i++) cyc(1, 8'hC0 + 8'(i), i == 3, 1, 1, '0);
        rd(13'd50);
        chk("t5 stale masked", 32'(rom_d), 32'(FILL));
        rd(13'd3);
        chk("t5 byte3", 32'(rom_d), 32'hC3);
        rd(13'd4);
        chk("t5 byte4 fill", 32'(rom_d), 32'(FILL));

        // random handshake, load_last on the top byte
        do_reset();
        n = 0;
        while (!m_loaded && n < 5 * DEPTH) begin
            cyc(1'($urandom), 8'($urandom), m_cnt == DEPTH - 1,
                1'($urandom), 1'($urandom), AW'($urandom));
            n++;
        end
        chk("t6 load finished", 32'(m_loaded), 1);
        chk("t6 loaded", 32'(loaded), 1);
        chk("t6 short_load", 32'(short_load), 0);
        for (int i = 0; i < 60; i++)
            cyc(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), AW'($urandom));
        for (int i = 0; i < 200; i++) rd(AW'($urandom));
        rd(13'd8191);
        chk("t6 top byte", 32'(rom_d), 32'(m_mem[DEPTH-1]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
